uart_tx_sched: RTL and testbench

Bus-master controller in front of the 16550-style UART. After reset it programs the UART configuration registers over the AXI-Lite-style register bus. It then shares the UART transmitter among N_REQ byte requesters using round-robin arbitration. Before each burst of THR writes it polls LSR.THRE, so the UART TX FIFO never overflows. The top level packs the m_* outputs into the UART's 32-bit command word: awvalid[0], wvalid[1], awaddr[4:2], bready[5], wdata[13:6], arvalid[15], araddr[18:16], rready[19].

---
 rtl/uart_tx_sched.sv | 210 +++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - UART init sequencer plus round-robin THR scheduler gated by LSR.THRE credits
module uart_tx_sched #(
    parameter int          N_REQ    = 4,
    parameter logic [15:0] DIVISOR  = 16'd27,
    parameter logic [7:0]  LCR_VAL  = 8'h03,
    parameter int          TX_BURST = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               cfg_restart,
    output logic               m_awvalid,
    output logic               m_wvalid,
    output logic               m_bready,
    output logic               m_arvalid,
    output logic               m_rready,
    output logic [2:0]         m_awaddr,
    output logic [7:0]         m_wdata,
    output logic [2:0]         m_araddr,
    input  logic               m_awready,
    input  logic               m_wready,
    input  logic               m_bvalid,
    input  logic               m_arready,
    input  logic               m_rvalid,
    input  logic [1:0]         m_bresp,
    input  logic [1:0]         m_rresp,
    input  logic [7:0]         m_rdata,
    output logic               init_done,
    output logic               busy,
    output logic               err
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TX_BURST + 1);

    typedef enum logic [2:0] {INIT_WR, IDLE, POLL_AR, POLL_R, TX_WR} state_t;

    state_t          state;
    logic [2:0]      step;
    logic            started;
    logic            wr_act;
    logic            restart_pend;
    logic [CW-1:0]   credits;
    logic [PW-1:0]   rr_ptr;

    logic [2:0]      init_addr;
    logic [7:0]      init_data;
    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   rr_next;
    logic [7:0]      gnt_data;

    // only LSR.THRE matters to the scheduler
    logic unused_rdata;
    assign unused_rdata = ^{m_rdata[7:6], m_rdata[4:0]};

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return PW'(s);
    endfunction

    // UART init program: DLAB on, divisor low/high, final LCR, FIFO enable+clear, IER off
    always_comb begin
        init_addr = 3'd0;
        init_data = 8'h00;
        case (step)
            3'd0: begin init_addr = 3'd3; init_data = 8'h80;          end
            3'd1: begin init_addr = 3'd0; init_data = DIVISOR[7:0];   end
            3'd2: begin init_addr = 3'd1; init_data = DIVISOR[15:8];  end
            3'd3: begin init_addr = 3'd3; init_data = LCR_VAL;        end
            3'd4: begin init_addr = 3'd2; init_data = 8'h07;          end
            default: begin init_addr = 3'd1; init_data = 8'h00;       end
        endcase
    end

    // round-robin search starting at rr_ptr, wrapping at N_REQ
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_found && req_valid[wrap_add(rr_ptr, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_add(rr_ptr, k);
            end
        end
        rr_next  = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
        gnt_data = req_data[{gnt_idx, 3'b000} +: 8];
    end

    // main sequencer: init writes, THRE polling, granted THR writes; all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT_WR;
            step         <= 3'd0;
            started      <= 1'b0;
            wr_act       <= 1'b0;
            restart_pend <= 1'b0;
            credits      <= '0;
            rr_ptr       <= '0;
            req_ready    <= '0;
            m_awvalid    <= 1'b0;
            m_wvalid     <= 1'b0;
            m_bready     <= 1'b0;
            m_arvalid    <= 1'b0;
            m_rready     <= 1'b0;
            m_awaddr     <= 3'd0;
            m_wdata      <= 8'h00;
            m_araddr     <= 3'd0;
            init_done    <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            req_ready <= '0;
            if (cfg_restart && state != IDLE) restart_pend <= 1'b1;

            case (state)
                INIT_WR, TX_WR: begin
                    if (!started) begin
                        // keeps outputs quiet for one more cycle after reset
                        started <= 1'b1;
                    end else if (!wr_act) begin
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        m_awaddr  <= init_addr;
                        m_wdata   <= init_data;
                        wr_act    <= 1'b1;
                        busy      <= 1'b1;
                    end else if (m_bready) begin
                        if (m_bvalid) begin
                            m_bready <= 1'b0;
                            wr_act   <= 1'b0;
                            if (m_bresp != 2'b00) err <= 1'b1;
                            if (state == TX_WR) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else if (step == 3'd5) begin
                                step      <= 3'd0;
                                init_done <= 1'b1;
                                state     <= IDLE;
                                busy      <= 1'b0;
                            end else begin
                                step <= step + 3'd1;
                            end
                        end
                    end else begin
                        if (m_awready) m_awvalid <= 1'b0;
                        if (m_wready)  m_wvalid  <= 1'b0;
                        if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready))
                            m_bready <= 1'b1;
                    end
                end

                IDLE: begin
                    if (cfg_restart || restart_pend) begin
                        restart_pend <= 1'b0;
                        init_done    <= 1'b0;
                        credits      <= '0;
                        wr_act       <= 1'b0;
                        step         <= 3'd0;
                        state        <= INIT_WR;
                        busy         <= 1'b1;
                    end else if (gnt_found) begin
                        if (credits == '0) begin
                            m_arvalid <= 1'b1;
                            m_araddr  <= 3'd5;
                            state     <= POLL_AR;
                            busy      <= 1'b1;
                        end else begin
                            req_ready[gnt_idx] <= 1'b1;
                            m_wdata   <= gnt_data;
                            m_awaddr  <= 3'd0;
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                            wr_act    <= 1'b1;
                            credits   <= credits - CW'(1);
                            rr_ptr    <= rr_next;
                            state     <= TX_WR;
                            busy      <= 1'b1;
                        end
                    end
                end

                POLL_AR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= POLL_R;
                    end
                end

                POLL_R: begin
                    if (m_rvalid) begin
                        m_rready <= 1'b0;
                        if (m_rresp != 2'b00) err <= 1'b1;
                        credits <= m_rdata[5] ? CW'(TX_BURST) : '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched with a UART register-bus slave model
module tb_uart_tx_sched;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           cfg_restart;
    logic           m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [2:0]     m_awaddr, m_araddr;
    logic [7:0]     m_wdata, m_rdata;
    logic           m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [1:0]     m_bresp, m_rresp;
    logic           init_done, busy, err;

    always #5 clk = ~clk;

    uart_tx_sched #(.N_REQ(N), .DIVISOR(16'd27), .LCR_VAL(8'h03), .TX_BURST(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cfg_restart(cfg_restart),
        .m_awvalid(m_awvalid), .m_wvalid(m_wvalid), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_wdata(m_wdata), .m_araddr(m_araddr),
        .m_awready(m_awready), .m_wready(m_wready), .m_bvalid(m_bvalid),
        .m_arready(m_arready), .m_rvalid(m_rvalid),
        .m_bresp(m_bresp), .m_rresp(m_rresp), .m_rdata(m_rdata),
        .init_done(init_done), .busy(busy), .err(err)
    );

    typedef struct packed {
        logic       is_wr;
        logic [2:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         gnt_q[$];
    logic [7:0] lsr_q[$];
    logic [7:0] rq[0:N-1][$];

    int         n_vec = 0;
    int         n_bad = 0;
    int         aw_delay = 0, w_delay = 0;
    logic [1:0] bresp_next = 2'b00;
    int         aw_wait, w_wait, aw_len, w_len, last_aw_len, last_w_len;
    int         gi;
    ev_t        ev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input logic [7:0] d);
        exp_q.push_back('{1'b1, 3'd0, d});
    endtask

    task automatic push_r(input logic [7:0] d);
        exp_q.push_back('{1'b0, 3'd5, d});
    endtask

    task automatic push_init();
        exp_q.push_back('{1'b1, 3'd3, 8'h80});
        exp_q.push_back('{1'b1, 3'd0, 8'h1B});
        exp_q.push_back('{1'b1, 3'd1, 8'h00});
        exp_q.push_back('{1'b1, 3'd3, 8'h03});
        exp_q.push_back('{1'b1, 3'd2, 8'h07});
        exp_q.push_back('{1'b1, 3'd1, 8'h00});
    endtask

    function automatic logic rq_pending();
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic log_event(input ev_t e);
        chk("ev_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("ev", 32'(e), 32'(exp_q.pop_front()));
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || gnt_q.size() != 0 || busy || rq_pending()) && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done"}, 32'(cyc < limit), 32'd1);
    endtask

    // slave model, requester model and output monitor, all acting on the falling edge
    initial begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
        m_bresp = 0; m_rresp = 0; m_rdata = 0;
        req_valid = '0; req_data = '0;
        aw_wait = 0; w_wait = 0; aw_len = 0; w_len = 0; last_aw_len = 0; last_w_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
                m_bresp = 0; m_rdata = 0;
                aw_wait = 0; w_wait = 0; aw_len = 0; w_len = 0;
            end else begin
                if (m_awvalid) begin
                    aw_len++;
                    if (aw_wait >= aw_delay) m_awready = 1;
                    else begin m_awready = 0; aw_wait++; end
                end else begin
                    m_awready = 0; aw_wait = 0;
                end
                if (m_wvalid) begin
                    w_len++;
                    if (w_wait >= w_delay) m_wready = 1;
                    else begin m_wready = 0; w_wait++; end
                end else begin
                    m_wready = 0; w_wait = 0;
                end
                if (m_bready) begin
                    m_bvalid = 1;
                    m_bresp = bresp_next;
                    bresp_next = 2'b00;
                    log_event('{1'b1, m_awaddr, m_wdata});
                    last_aw_len = aw_len; last_w_len = w_len;
                    aw_len = 0; w_len = 0;
                end else begin
                    m_bvalid = 0; m_bresp = 0;
                end
                m_arready = m_arvalid;
                if (m_rready) begin
                    m_rvalid = 1;
                    m_rdata = (lsr_q.size() != 0) ? lsr_q.pop_front() : 8'h60;
                    log_event('{1'b0, m_araddr, m_rdata});
                end else begin
                    m_rvalid = 0; m_rdata = 0;
                end
                if (req_ready != '0) begin
                    gi = 0;
                    for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
                    chk("gnt_onehot", 32'($countones(req_ready)), 32'd1);
                    chk("gnt_expected", 32'(gnt_q.size() != 0), 32'd1);
                    if (gnt_q.size() != 0) chk("gnt_idx", 32'(gi), 32'(gnt_q.pop_front()));
                    chk("gnt_after_poll", 32'(exp_q.size() != 0 && exp_q[0].is_wr), 32'd1);
                    if (rq[gi].size() != 0) void'(rq[gi].pop_front());
                end
            end
            for (int i = 0; i < N; i++) begin
                req_valid[i] = (rq[i].size() != 0);
                req_data[8*i +: 8] = (rq[i].size() != 0) ? rq[i][0] : 8'h00;
            end
        end
    end

    // directed sequence
    initial begin
        int cyc;
        rst = 1'b1;
        cfg_restart = 1'b0;
        push_init();
        @(negedge clk);
        @(negedge clk);
        chk("rst_outputs", 32'({req_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                                m_awaddr, m_wdata, m_araddr, init_done, busy, err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outputs", 32'({req_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                                     m_awaddr, m_wdata, m_araddr, init_done, busy, err}), 32'd0);
        wait_idle("init", 300);
        chk("init_done", 32'(init_done), 32'd1);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_err", 32'(err), 32'd0);

        // two requesters alternate after a single poll
        push_r(8'h60);
        for (int k = 0; k < 3; k++) begin
            push_w(8'hA0); gnt_q.push_back(0);
            push_w(8'hA2); gnt_q.push_back(2);
        end
        for (int k = 0; k < 3; k++) begin
            rq[0].push_back(8'hA0);
            rq[2].push_back(8'hA2);
        end
        wait_idle("rr_alt", 500);
        chk("rr_alt_err", 32'(err), 32'd0);

        // restart from idle: full init replay, credits cleared
        push_init();
        cfg_restart = 1'b1;
        @(negedge clk);
        cfg_restart = 1'b0;
        chk("restart_clears_init_done", 32'(init_done), 32'd0);
        wait_idle("restart1", 300);
        chk("restart1_init_done", 32'(init_done), 32'd1);

        // 20-byte stream: 16 writes per THRE credit, then re-poll
        push_r(8'h60);
        for (int k = 0; k < 16; k++) begin push_w(8'h10 + 8'(k)); gnt_q.push_back(1); end
        push_r(8'h60);
        for (int k = 16; k < 20; k++) begin push_w(8'h10 + 8'(k)); gnt_q.push_back(1); end
        for (int k = 0; k < 20; k++) rq[1].push_back(8'h10 + 8'(k));
        wait_idle("burst", 1500);

        push_init();
        cfg_restart = 1'b1;
        @(negedge clk);
        cfg_restart = 1'b0;
        wait_idle("restart2", 300);

        // THRE=0 keeps re-polling without granting
        lsr_q.push_back(8'h00); lsr_q.push_back(8'h00);
        lsr_q.push_back(8'h00); lsr_q.push_back(8'h20);
        push_r(8'h00); push_r(8'h00); push_r(8'h00); push_r(8'h20);
        push_w(8'h33); gnt_q.push_back(3);
        rq[3].push_back(8'h33);
        wait_idle("thre_low", 300);
        chk("thre_low_err", 32'(err), 32'd0);

        // slow slave with SLVERR on a THR write
        aw_delay = 3; w_delay = 1; bresp_next = 2'b10;
        push_w(8'h55); gnt_q.push_back(0);
        rq[0].push_back(8'h55);
        wait_idle("slow_wr", 200);
        chk("slow_aw_cycles", 32'(last_aw_len), 32'd4);
        chk("slow_w_cycles", 32'(last_w_len), 32'd2);
        chk("slverr_err", 32'(err), 32'd1);
        aw_delay = 0; w_delay = 0;
        push_w(8'h66); gnt_q.push_back(1);
        rq[1].push_back(8'h66);
        wait_idle("after_err", 200);
        chk("err_sticky", 32'(err), 32'd1);
        chk("fast_aw_cycles", 32'(last_aw_len), 32'd1);

        // restart during a THR write: write finishes, init replays, rr_ptr kept, re-poll
        push_w(8'h77); gnt_q.push_back(2);
        push_init();
        push_r(8'h60);
        push_w(8'h78); gnt_q.push_back(3);
        push_w(8'h71); gnt_q.push_back(1);
        rq[1].push_back(8'h71); rq[2].push_back(8'h77); rq[3].push_back(8'h78);
        cyc = 0;
        while (!m_awvalid && cyc < 50) begin @(negedge clk); cyc++; end
        chk("tx_wr_seen", 32'(cyc < 50), 32'd1);
        cfg_restart = 1'b1;
        @(negedge clk);
        cfg_restart = 1'b0;
        cyc = 0;
        while (!(m_awvalid && m_awaddr == 3'd3 && m_wdata == 8'h80) && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        chk("replay_start_seen", 32'(cyc < 100), 32'd1);
        chk("replay_init_done_low", 32'(init_done), 32'd0);
        wait_idle("restart_mid", 500);
        chk("final_init_done", 32'(init_done), 32'd1);
        chk("final_err_sticky", 32'(err), 32'd1);
        chk("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
